// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse transmitter.
package morse_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMark,
        StSpace,
        StLgap,
        StWgap
    } state_t;

    localparam int unsigned DASH_UNITS       = 3;
    localparam int unsigned LETTER_GAP_UNITS = 3;
    localparam int unsigned WORD_GAP_UNITS   = 7;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // pat is left-aligned: pat[4] is the first element, 1 = dash.
    typedef struct packed {
        logic       valid;
        logic [2:0] len;
        logic [4:0] pat;
    } lut_t;

endpackage

// File: rtl/morse_tx_if.sv
// Character handshake between a producer and the Morse transmitter.
interface morse_tx_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (output char_in, output char_valid, input char_ready);
    modport slave  (input char_in, input char_valid, output char_ready);
endinterface

// File: rtl/morse_lut.sv
// ASCII to Morse code lookup; lowercase letters fold onto uppercase.
module morse_lut
    import morse_pkg::*;
(
    input  logic [7:0] char_in,
    output lut_t       code
);

    logic [7:0] up;

    always_comb begin
        up = char_in;
        if (char_in >= 8'h61 && char_in <= 8'h7a) begin
            up = char_in - 8'h20;
        end
    end

    always_comb begin
        code = '0;
        code.valid = 1'b1;
        unique case (up)
            8'h41: {code.len, code.pat} = {3'd2, 5'b01000}; // A
            8'h42: {code.len, code.pat} = {3'd4, 5'b10000};
            8'h43: {code.len, code.pat} = {3'd4, 5'b10100};
            8'h44: {code.len, code.pat} = {3'd3, 5'b10000};
            8'h45: {code.len, code.pat} = {3'd1, 5'b00000};
            8'h46: {code.len, code.pat} = {3'd4, 5'b00100};
            8'h47: {code.len, code.pat} = {3'd3, 5'b11000};
            8'h48: {code.len, code.pat} = {3'd4, 5'b00000};
            8'h49: {code.len, code.pat} = {3'd2, 5'b00000};
            8'h4a: {code.len, code.pat} = {3'd4, 5'b01110};
            8'h4b: {code.len, code.pat} = {3'd3, 5'b10100};
            8'h4c: {code.len, code.pat} = {3'd4, 5'b01000};
            8'h4d: {code.len, code.pat} = {3'd2, 5'b11000};
            8'h4e: {code.len, code.pat} = {3'd2, 5'b10000};
            8'h4f: {code.len, code.pat} = {3'd3, 5'b11100};
            8'h50: {code.len, code.pat} = {3'd4, 5'b01100};
            8'h51: {code.len, code.pat} = {3'd4, 5'b11010};
            8'h52: {code.len, code.pat} = {3'd3, 5'b01000};
            8'h53: {code.len, code.pat} = {3'd3, 5'b00000};
            8'h54: {code.len, code.pat} = {3'd1, 5'b10000};
            8'h55: {code.len, code.pat} = {3'd3, 5'b00100};
            8'h56: {code.len, code.pat} = {3'd4, 5'b00010};
            8'h57: {code.len, code.pat} = {3'd3, 5'b01100};
            8'h58: {code.len, code.pat} = {3'd4, 5'b10010};
            8'h59: {code.len, code.pat} = {3'd4, 5'b10110};
            8'h5a: {code.len, code.pat} = {3'd4, 5'b11000}; // Z
            8'h30: {code.len, code.pat} = {3'd5, 5'b11111}; // 0
            8'h31: {code.len, code.pat} = {3'd5, 5'b01111};
            8'h32: {code.len, code.pat} = {3'd5, 5'b00111};
            8'h33: {code.len, code.pat} = {3'd5, 5'b00011};
            8'h34: {code.len, code.pat} = {3'd5, 5'b00001};
            8'h35: {code.len, code.pat} = {3'd5, 5'b00000};
            8'h36: {code.len, code.pat} = {3'd5, 5'b10000};
            8'h37: {code.len, code.pat} = {3'd5, 5'b11000};
            8'h38: {code.len, code.pat} = {3'd5, 5'b11100};
            8'h39: {code.len, code.pat} = {3'd5, 5'b11110}; // 9
            default: code = '0;
        endcase
    end

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: one ASCII char per handshake, keyed out with unit timing.
module morse_tx
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    morse_tx_if.slave        bus,
    output logic             key_out,
    output logic             busy,
    output logic             err
);

    localparam int unsigned CntW = $clog2(WORD_GAP_UNITS * UNIT_CYCLES);

    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] DotLoad  = CntW'(UNIT_CYCLES - 1);
    localparam logic [CntW-1:0] DashLoad = CntW'(DASH_UNITS * UNIT_CYCLES - 1);
    // The IDLE cycle that ends a gap is itself the last low cycle of that gap,
    // so a char accepted on the first IDLE cycle keeps the gap exact.
    localparam logic [CntW-1:0] LgapLoad = CntW'(LETTER_GAP_UNITS * UNIT_CYCLES - 2);
    localparam logic [CntW-1:0] WgapLoad = CntW'(WORD_GAP_UNITS * UNIT_CYCLES - 2);

    state_t          state;
    logic [CntW-1:0] cnt;
    logic [2:0]      idx;
    logic [2:0]      len;
    logic [4:0]      pat_sr;
    lut_t            code;
    logic            accept;

    morse_lut u_lut (
        .char_in (bus.char_in),
        .code    (code)
    );

    assign bus.char_ready = (state == StIdle);
    assign accept         = bus.char_valid && (state == StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= StIdle;
            cnt     <= '0;
            idx     <= '0;
            len     <= '0;
            pat_sr  <= '0;
            key_out <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        if (bus.char_in == ASCII_SPACE) begin
                            state <= StWgap;
                            busy  <= 1'b1;
                            cnt   <= WgapLoad;
                        end else if (code.valid) begin
                            state   <= StMark;
                            busy    <= 1'b1;
                            key_out <= 1'b1;
                            pat_sr  <= code.pat;
                            len     <= code.len;
                            idx     <= '0;
                            cnt     <= code.pat[4] ? DashLoad : DotLoad;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StMark: begin
                    if (cnt == '0) begin
                        key_out <= 1'b0;
                        if (idx == len - 3'd1) begin
                            state <= StLgap;
                            cnt   <= LgapLoad;
                        end else begin
                            state  <= StSpace;
                            cnt    <= DotLoad;
                            idx    <= idx + 3'd1;
                            pat_sr <= {pat_sr[3:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt - CntOne;
                    end
                end
                StSpace: begin
                    if (cnt == '0) begin
                        state   <= StMark;
                        key_out <= 1'b1;
                        cnt     <= pat_sr[4] ? DashLoad : DotLoad;
                    end else begin
                        cnt <= cnt - CntOne;
                    end
                end
                StLgap, StWgap: begin
                    if (cnt == '0) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CntOne;
                    end
                end
                default: begin
                    state   <= StIdle;
                    key_out <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx with UNIT_CYCLES=4; cycle 0 is the accept edge.
module tb_morse_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_out;
    logic busy;
    logic err;

    int total = 0;
    int bad = 0;

    morse_tx_if bus ();

    morse_tx #(.UNIT_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .key_out (key_out),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a char for exactly one edge, then scribble on char_in.
    task automatic send(input logic [7:0] c);
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        tick();
        bus.char_valid = 1'b0;
        bus.char_in    = 8'h54;
    endtask

    task automatic run(input string tag, input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_key"}, key_out, lvl);
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_ready"}, bus.char_ready, 1'b0);
            tick();
        end
    endtask

    task automatic idle_chk(input string tag);
        check({tag, "_key"}, key_out, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ready"}, bus.char_ready, 1'b1);
    endtask

    initial begin
        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        reset          = 1'b1;
        tick();
        tick();
        check("rst_key", key_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        reset = 1'b0;
        tick();
        check("rst_ready", bus.char_ready, 1'b1);

        // 'E': one dot, then letter gap
        send(8'h45);
        run("e_mark", 1'b1, 4);
        run("e_gap", 1'b0, 11);
        idle_chk("e_end");

        // 'A' then 'a': identical waveforms
        for (int k = 0; k < 2; k++) begin
            send(k == 0 ? 8'h41 : 8'h61);
            run("a_dot", 1'b1, 4);
            run("a_sp", 1'b0, 4);
            run("a_dash", 1'b1, 12);
            run("a_gap", 1'b0, 11);
            idle_chk("a_end");
        end

        // '0': five dashes
        send(8'h30);
        for (int k = 0; k < 5; k++) begin
            run("z_dash", 1'b1, 12);
            if (k < 4) run("z_sp", 1'b0, 4);
        end
        run("z_gap", 1'b0, 11);
        idle_chk("z_end");

        // "EE" with valid held high: second mark begins at cycle 16
        bus.char_in    = 8'h45;
        bus.char_valid = 1'b1;
        tick();
        run("ee1_mark", 1'b1, 4);
        run("ee1_gap", 1'b0, 11);
        idle_chk("ee1_end");
        tick();
        bus.char_valid = 1'b0;
        run("ee2_mark", 1'b1, 4);
        run("ee2_gap", 1'b0, 11);
        idle_chk("ee2_end");

        // "E E": 12 low for the letter gap, then 28 for the word gap
        send(8'h45);
        run("ese1_mark", 1'b1, 4);
        run("ese1_gap", 1'b0, 11);
        idle_chk("ese1_end");
        send(8'h20);
        run("ese_wgap", 1'b0, 27);
        idle_chk("ese_wend");
        send(8'h45);
        run("ese2_mark", 1'b1, 4);
        run("ese2_gap", 1'b0, 11);
        idle_chk("ese2_end");

        // '#': unsupported
        send(8'h23);
        check("bad_err", err, 1'b1);
        idle_chk("bad_c0");
        tick();
        check("bad_err_clr", err, 1'b0);
        check("bad_key", key_out, 1'b0);

        // Reset in the middle of 'T'
        send(8'h54);
        run("t_mark", 1'b1, 6);
        reset = 1'b1;
        tick();
        check("trst_key", key_out, 1'b0);
        check("trst_busy", busy, 1'b0);
        reset = 1'b0;
        tick();
        idle_chk("trst_idle");
        send(8'h45);
        run("post_mark", 1'b1, 4);
        run("post_gap", 1'b0, 11);
        idle_chk("post_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
